// File: rtl/mac_tx_pkg.sv
// Shared types and defaults for the multi-channel MAC transmit arbiter.
package mac_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MREQ = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam int IFG_CYCLES_DEF     = 12;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    // Bits needed for a counter running 0..n-1, never narrower than 1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_tx_arb_n_if.sv
// Frame-source and MAC-core signals of the transmit arbiter.
interface mac_tx_arb_n_if #(
    parameter int NUM_CH = 4
);
    localparam int GW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]   ch_tx_req;
    logic [NUM_CH-1:0]   ch_tx_ack;
    logic [NUM_CH-1:0]   ch_tx_ready;
    logic [8*NUM_CH-1:0] ch_tx_data;
    logic [NUM_CH-1:0]   ch_tx_end;
    logic                mac_tx_req;
    logic                mac_tx_ack;
    logic                mac_tx_ready;
    logic [7:0]          mac_tx_data;
    logic                mac_tx_end;
    logic                mac_send_end;
    logic [GW-1:0]       grant_ch;
    logic                busy;
    logic                timeout_err;

    modport slave (
        input  ch_tx_req, ch_tx_ready, ch_tx_data, ch_tx_end,
        input  mac_tx_ack, mac_send_end,
        output ch_tx_ack, mac_tx_req, mac_tx_ready, mac_tx_data,
        output mac_tx_end, grant_ch, busy, timeout_err
    );

    modport master (
        output ch_tx_req, ch_tx_ready, ch_tx_data, ch_tx_end,
        output mac_tx_ack, mac_send_end,
        input  ch_tx_ack, mac_tx_req, mac_tx_ready, mac_tx_data,
        input  mac_tx_end, grant_ch, busy, timeout_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last,
    output logic [$clog2(NUM_CH)-1:0] idx
);
    localparam int GW = $clog2(NUM_CH);

    logic [GW-1:0] cand;

    // Walk farthest-first so the nearest requester overwrites last.
    always_comb begin
        idx  = last;
        cand = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = GW'((int'(last) + i) % NUM_CH);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mac_tx_arb_n.sv
// N-source frame arbiter in front of the MAC core, with IFG and watchdog.
module mac_tx_arb_n
    import mac_tx_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int PRIO_CH0       = 1
) (
    input logic           clk,
    input logic           rst_n,
    mac_tx_arb_n_if.slave bus
);
    localparam int GW      = $clog2(NUM_CH);
    localparam int WW      = cnt_w(TIMEOUT_CYCLES);
    localparam int FW      = cnt_w(IFG_CYCLES);
    localparam int GAP_END = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] GAP_LAST = FW'(GAP_END);
    localparam tx_state_e     DONE_ST  =
        (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

    tx_state_e         state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [FW-1:0]     gap_q, gap_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              req_q, req_d;
    logic              to_q, to_d;

    logic [GW-1:0] rr_idx;
    logic [GW-1:0] win;
    logic          wd_exp;
    logic          sending;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req  (bus.ch_tx_req),
        .last (last_q),
        .idx  (rr_idx)
    );

    assign win    = (PRIO_CH0 != 0 && bus.ch_tx_req[0]) ? '0 : rr_idx;
    assign wd_exp = (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        ack_d   = '0;
        req_d   = req_q;
        to_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.ch_tx_req) begin
                    grant_d = win;
                    wd_d    = '0;
                    req_d   = 1'b1;
                    state_d = ST_MREQ;
                end
            end
            ST_MREQ: begin
                wd_d = wd_q + WW'(1);
                // An expired watchdog aborts even if the MAC accepts now.
                if (wd_exp) begin
                    to_d    = 1'b1;
                    req_d   = 1'b0;
                    gap_d   = '0;
                    state_d = DONE_ST;
                end else if (bus.mac_tx_ack) begin
                    ack_d[grant_q] = 1'b1;
                    last_d  = grant_q;
                    req_d   = 1'b0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                wd_d = wd_q + WW'(1);
                if (bus.mac_send_end) begin
                    gap_d   = '0;
                    state_d = DONE_ST;
                end else if (wd_exp) begin
                    to_d    = 1'b1;
                    gap_d   = '0;
                    state_d = DONE_ST;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + FW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
            wd_q    <= '0;
            gap_q   <= '0;
            ack_q   <= '0;
            req_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            to_q    <= to_d;
        end
    end

    assign sending = (state_q == ST_SEND);

    assign bus.ch_tx_ack    = ack_q;
    assign bus.mac_tx_req   = req_q;
    assign bus.grant_ch     = grant_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.timeout_err  = to_q;
    assign bus.mac_tx_ready = sending & bus.ch_tx_ready[grant_q];
    assign bus.mac_tx_end   = sending & bus.ch_tx_end[grant_q];
    assign bus.mac_tx_data  =
        sending ? bus.ch_tx_data[{grant_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mac_tx_arb_n.sv
// Bench for mac_tx_arb_n: two configurations driven against a frame-level model.
module tb_mac_tx_arb_n;
    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int IFG_A = 12;
    localparam int IFG_B = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_tx_arb_n_if #(.NUM_CH(N)) ia ();
    mac_tx_arb_n_if #(.NUM_CH(N)) ib ();

    mac_tx_arb_n #(
        .NUM_CH(N), .IFG_CYCLES(IFG_A), .TIMEOUT_CYCLES(TO), .PRIO_CH0(1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

    mac_tx_arb_n #(
        .NUM_CH(N), .IFG_CYCLES(IFG_B), .TIMEOUT_CYCLES(TO), .PRIO_CH0(0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    logic [N-1:0]   req[2], rdy[2], endf[2];
    logic [8*N-1:0] dat[2];
    logic           mack[2], msend[2];

    logic [N-1:0] ack_o[2];
    logic         mreq_o[2], mrdy_o[2], mend_o[2], busy_o[2], to_o[2];
    logic [7:0]   mdat_o[2];
    logic [1:0]   gnt_o[2];

    assign ia.ch_tx_req    = req[0];
    assign ia.ch_tx_ready  = rdy[0];
    assign ia.ch_tx_data   = dat[0];
    assign ia.ch_tx_end    = endf[0];
    assign ia.mac_tx_ack   = mack[0];
    assign ia.mac_send_end = msend[0];
    assign ib.ch_tx_req    = req[1];
    assign ib.ch_tx_ready  = rdy[1];
    assign ib.ch_tx_data   = dat[1];
    assign ib.ch_tx_end    = endf[1];
    assign ib.mac_tx_ack   = mack[1];
    assign ib.mac_send_end = msend[1];

    assign ack_o[0]  = ia.ch_tx_ack;    assign ack_o[1]  = ib.ch_tx_ack;
    assign mreq_o[0] = ia.mac_tx_req;   assign mreq_o[1] = ib.mac_tx_req;
    assign mrdy_o[0] = ia.mac_tx_ready; assign mrdy_o[1] = ib.mac_tx_ready;
    assign mdat_o[0] = ia.mac_tx_data;  assign mdat_o[1] = ib.mac_tx_data;
    assign mend_o[0] = ia.mac_tx_end;   assign mend_o[1] = ib.mac_tx_end;
    assign busy_o[0] = ia.busy;         assign busy_o[1] = ib.busy;
    assign to_o[0]   = ia.timeout_err;  assign to_o[1]   = ib.timeout_err;
    assign gnt_o[0]  = ia.grant_ch;     assign gnt_o[1]  = ib.grant_ch;

    int passed = 0;
    int total  = 0;
    int last_m[2];

    // Spec rule: ch0 first when prioritised, else first requester after last.
    function automatic int arb(input logic [N-1:0] r, input int last, input logic pr);
        if (pr && r[0]) return 0;
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return 0;
    endfunction

    task automatic rand_ch(input int u);
        rdy[u]  = 4'($urandom);
        dat[u]  = $urandom;
        endf[u] = 4'($urandom);
    endtask

    task automatic check_zero(input int u, input string tag);
        total++;
        if ({ack_o[u], mreq_o[u], busy_o[u], to_o[u], gnt_o[u],
             mrdy_o[u], mdat_o[u], mend_o[u]} !== 19'b0)
            $display("FAIL %s u%0d outputs: got %b want all zero", tag, u,
                     {ack_o[u], mreq_o[u], busy_o[u], to_o[u], gnt_o[u],
                      mrdy_o[u], mdat_o[u], mend_o[u]});
        else passed++;
    endtask

    // Caller has applied a nonzero req[u] in an IDLE cycle; nxt is applied on the next IDLE cycle.
    task automatic do_frame(input int u, input int d, input int len, input bit do_ack,
                            input logic [N-1:0] nxt, input int want, input string tag);
        int w;
        int ifg;
        logic [N-1:0] ea;
        ifg = (u == 0) ? IFG_A : IFG_B;
        w = (want >= 0) ? want : arb(req[u], last_m[u], u == 0);
        if (do_ack) begin
            for (int k = 0; k <= d; k++) begin
                @(negedge clk); mack[u] = (k == d); rand_ch(u); #1;
                total++;
                if ({busy_o[u], mreq_o[u], ack_o[u], to_o[u], gnt_o[u]} !==
                    {1'b1, 1'b1, 4'b0, 1'b0, 2'(w)})
                    $display("FAIL %s mreq c%0d: got %b want %b", tag, k,
                             {busy_o[u], mreq_o[u], ack_o[u], to_o[u], gnt_o[u]},
                             {1'b1, 1'b1, 4'b0, 1'b0, 2'(w)});
                else passed++;
                total++;
                if ({mrdy_o[u], mdat_o[u], mend_o[u]} !== 10'b0)
                    $display("FAIL %s mreq mux c%0d: got %h want 0", tag, k,
                             {mrdy_o[u], mdat_o[u], mend_o[u]});
                else passed++;
            end
            last_m[u] = w;
            for (int k = 0; k < len; k++) begin
                @(negedge clk); mack[u] = 1'b0;
                if (k == 0) req[u][w] = 1'b0;
                rand_ch(u); msend[u] = (k == len - 1); #1;
                ea = (k == 0) ? 4'(1 << w) : 4'b0;
                total++;
                if ({busy_o[u], mreq_o[u], ack_o[u], to_o[u], gnt_o[u]} !==
                    {1'b1, 1'b0, ea, 1'b0, 2'(w)})
                    $display("FAIL %s send ctl k%0d: got %b want %b", tag, k,
                             {busy_o[u], mreq_o[u], ack_o[u], to_o[u], gnt_o[u]},
                             {1'b1, 1'b0, ea, 1'b0, 2'(w)});
                else passed++;
                total++;
                if ({mrdy_o[u], mdat_o[u], mend_o[u]} !==
                    {rdy[u][w], dat[u][8*w +: 8], endf[u][w]})
                    $display("FAIL %s send mux k%0d: got %h want %h", tag, k,
                             {mrdy_o[u], mdat_o[u], mend_o[u]},
                             {rdy[u][w], dat[u][8*w +: 8], endf[u][w]});
                else passed++;
            end
        end else begin
            mack[u] = 1'b0;
            for (int k = 0; k < TO; k++) begin
                @(negedge clk); rand_ch(u); #1;
                total++;
                if ({busy_o[u], mreq_o[u], ack_o[u], to_o[u], gnt_o[u]} !==
                    {1'b1, 1'b1, 4'b0, 1'b0, 2'(w)})
                    $display("FAIL %s wait c%0d: got %b want %b", tag, k,
                             {busy_o[u], mreq_o[u], ack_o[u], to_o[u], gnt_o[u]},
                             {1'b1, 1'b1, 4'b0, 1'b0, 2'(w)});
                else passed++;
            end
        end
        @(negedge clk); msend[u] = 1'b0; mack[u] = 1'b0; rand_ch(u);
        if (ifg == 0) req[u] = nxt;
        #1;
        total++;
        if ({busy_o[u], mreq_o[u], ack_o[u], to_o[u]} !==
            {ifg > 0, 1'b0, 4'b0, !do_ack})
            $display("FAIL %s post: got %b want %b", tag,
                     {busy_o[u], mreq_o[u], ack_o[u], to_o[u]},
                     {ifg > 0, 1'b0, 4'b0, !do_ack});
        else passed++;
        for (int g = 1; g < ifg; g++) begin
            @(negedge clk); rand_ch(u); #1;
            total++;
            if ({busy_o[u], mreq_o[u], ack_o[u], to_o[u], mrdy_o[u], mdat_o[u], mend_o[u]}
                !== {1'b1, 16'b0})
                $display("FAIL %s gap g%0d: got %b want busy only", tag, g,
                         {busy_o[u], mreq_o[u], ack_o[u], to_o[u],
                          mrdy_o[u], mdat_o[u], mend_o[u]});
            else passed++;
        end
        if (ifg > 0) begin
            @(negedge clk); req[u] = nxt; rand_ch(u); #1;
            total++;
            if ({busy_o[u], mreq_o[u], ack_o[u], to_o[u], mrdy_o[u], mdat_o[u], mend_o[u]}
                !== 17'b0)
                $display("FAIL %s idle: got %b want 0", tag,
                         {busy_o[u], mreq_o[u], ack_o[u], to_o[u],
                          mrdy_o[u], mdat_o[u], mend_o[u]});
            else passed++;
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            req[u] = 4'hF; mack[u] = 1'b1; msend[u] = 1'b1; rand_ch(u);
        end
        repeat (2) begin
            @(negedge clk); #1;
            check_zero(0, "reset"); check_zero(1, "reset");
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            req[u] = '0; mack[u] = 1'b0; msend[u] = 1'b0;
        end
        rst_n = 1'b1; #1;
        check_zero(0, "release"); check_zero(1, "release");
        last_m[0] = N - 1; last_m[1] = N - 1;
    endtask

    task automatic test_single();
        @(negedge clk); req[0] = 4'b0100;
        do_frame(0, 2, 5, 1'b1, 4'b0, 2, "single");
    endtask

    task automatic test_fairness();
        @(negedge clk); req[1] = 4'b1110;
        do_frame(1, 1, 3, 1'b1, 4'b1110, 1, "fair1");
        do_frame(1, 0, 4, 1'b1, 4'b1110, 2, "fair2");
        do_frame(1, 2, 2, 1'b1, 4'b1110, 3, "fair3");
        do_frame(1, 0, 3, 1'b1, 4'b0000, 1, "fair4");
    endtask

    task automatic test_priority();
        @(negedge clk); req[0] = 4'b1001;
        do_frame(0, 0, 2, 1'b1, 4'b1001, 0, "prio1");
        do_frame(0, 1, 3, 1'b1, 4'b1001, 0, "prio2");
        do_frame(0, 0, 2, 1'b1, 4'b1000, 0, "prio3");
        do_frame(0, 0, 2, 1'b1, 4'b0010, 3, "prio_ch3");
    endtask

    task automatic test_timeout();
        do_frame(0, 0, 0, 1'b0, 4'b0110, 1, "timeout");
        do_frame(0, 1, 3, 1'b1, 4'b0000, 1, "after_to");
    endtask

    task automatic test_coincide();
        @(negedge clk); req[0] = 4'b0100;
        do_frame(0, 4, 11, 1'b1, 4'b0000, 2, "coincide");
    endtask

    task automatic test_reset_mid();
        @(negedge clk); req[0] = 4'b0100;
        @(negedge clk); mack[0] = 1'b1;
        @(negedge clk); mack[0] = 1'b0; req[0] = '0;
        rdy[0] = 4'hF; dat[0] = 32'hFFFF_FFFF; endf[0] = 4'hF;
        @(negedge clk); #1;
        total++;
        if ({busy_o[0], mrdy_o[0], mdat_o[0], gnt_o[0]} !== {1'b1, 1'b1, 8'hFF, 2'd2})
            $display("FAIL pre_reset send: got %b want %b",
                     {busy_o[0], mrdy_o[0], mdat_o[0], gnt_o[0]}, {1'b1, 1'b1, 8'hFF, 2'd2});
        else passed++;
        rst_n = 1'b0; #1;
        check_zero(0, "rst_mid"); check_zero(1, "rst_mid");
        @(negedge clk); rst_n = 1'b1;
        rdy[0] = '0; dat[0] = '0; endf[0] = '0;
        last_m[0] = N - 1; last_m[1] = N - 1;
        repeat (3) begin
            @(negedge clk); #1;
            check_zero(0, "rst_after"); check_zero(1, "rst_after");
        end
        @(negedge clk); req[1] = 4'b0101;
        do_frame(1, 0, 2, 1'b1, 4'b0000, 0, "rst_next");
    endtask

    task automatic test_random();
        int d;
        int len;
        bit a;
        logic [N-1:0] nxt;
        for (int u = 0; u < 2; u++) begin
            @(negedge clk); req[u] = 4'($urandom_range(1, 15));
            for (int f = 0; f < 12; f++) begin
                d   = $urandom_range(0, 4);
                len = $urandom_range(1, 15 - d);
                a   = ($urandom_range(0, 5) != 0);
                nxt = (f == 11) ? 4'b0 : 4'($urandom_range(1, 15));
                do_frame(u, d, len, a, nxt, -1, "rand");
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req[u] = '0; rdy[u] = '0; dat[u] = '0; endf[u] = '0;
            mack[u] = 1'b0; msend[u] = 1'b0; last_m[u] = N - 1;
        end
        test_reset();
        test_single();
        test_fairness();
        test_priority();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mac_tx_arb_n.md
MAC_TX_ARB_N -- requirements
Module: mac_tx_arb_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of frame sources (2..8).
REQ-002 SHALL have parameter IFG_CYCLES, default 12, idle cycles enforced after each frame (0 = none).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit per grant.
REQ-004 SHALL have parameter PRIO_CH0, default 1, where 1 gives channel 0 (ARP) strict priority and 0 gives pure round-robin.
REQ-005 SHALL have port clk  input  1  single clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ch_tx_req  input  NUM_CH  per-channel frame request, held by the source until acked.
REQ-008 SHALL have port ch_tx_ack  output  NUM_CH  one-cycle grant pulse to the winning channel.
REQ-009 SHALL have port ch_tx_ready  input  NUM_CH  per-channel frame-data-ready.
REQ-010 SHALL have port ch_tx_data  input  8*NUM_CH  per-channel byte, with channel k at bits [8k+7:8k].
REQ-011 SHALL have port ch_tx_end  input  NUM_CH  per-channel last-byte flag.
REQ-012 SHALL have port mac_tx_req  output  1  request to the MAC core.
REQ-013 SHALL have port mac_tx_ack  input  1  MAC core accept.
REQ-014 SHALL have port mac_tx_ready, mac_tx_data[7:0], mac_tx_end  output  1/8/1  muxed frame stream.
REQ-015 SHALL have port mac_send_end  input  1  MAC frame (incl. CRC) finished.
REQ-016 SHALL have port grant_ch  output  clog2(NUM_CH)  current/last granted channel.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-019 SHALL implement the FSM states IDLE, MREQ, SEND and GAP.
REQ-020 IDLE SHALL, when any ch_tx_req bit is set, register the winner into grant_ch and go to MREQ on the next edge.
REQ-021 Arbitration SHALL select channel 0 if PRIO_CH0=1 and ch_tx_req[0]=1; otherwise it SHALL select the first requesting channel searching from last_grant+1 modulo NUM_CH.
REQ-022 MREQ SHALL hold mac_tx_req=1 until mac_tx_ack is sampled high; on that same edge ch_tx_ack[grant_ch] SHALL pulse for exactly 1 cycle, mac_tx_req SHALL drop, and the FSM SHALL go to SEND.
REQ-023 In SEND, mac_tx_ready, mac_tx_data and mac_tx_end SHALL be combinational copies of the granted channel's ch_tx_ready, ch_tx_data and ch_tx_end, with zero latency; in all other states they SHALL be 0.
REQ-024 SEND SHALL go to GAP on mac_send_end=1.
REQ-025 GAP SHALL count exactly IFG_CYCLES cycles and then go to IDLE; if IFG_CYCLES=0, the FSM SHALL go SEND->IDLE directly.
REQ-026 The watchdog SHALL clear on entry to MREQ and count in MREQ and SEND; when it reaches TIMEOUT_CYCLES-1, timeout_err SHALL pulse for 1 cycle, the FSM SHALL go to GAP, and no ch_tx_ack SHALL be issued if the abort occurs in MREQ.
REQ-027 last_grant SHALL update only when ch_tx_ack is issued; an aborted MREQ SHALL not advance fairness.
REQ-028 Requests arriving outside IDLE SHALL not be lost: they remain pending as levels and are arbitrated on the next IDLE cycle.
REQ-029 If mac_send_end and watchdog expiry coincide, mac_send_end SHALL win and timeout_err SHALL not pulse.
REQ-030 A request that drops before grant SHALL simply not be selected; the block SHALL not latch requests.
REQ-031 ch_tx_ack SHALL be one-hot or zero in every cycle.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, mac_tx_req=0, ch_tx_ack=0, timeout_err=0, grant_ch=0, counters=0, last_grant=NUM_CH-1 (so channel 0 wins the first round-robin), and muxed outputs=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately, and no ack or timeout pulse SHALL follow release.

Structure
REQ-034 State encoding and the default IFG/timeout constants SHALL reside in a shared package mac_tx_pkg.
REQ-035 The round-robin selector SHALL be one sub-module, rr_arbiter (NUM_CH-bit request, last-grant in, index out, purely combinational); the FSM, counters and mux SHALL stay in the top module.
REQ-036 The block SHALL replace the fixed two-input ARP/IP mode selector between the protocol TX modules and mac_tx.

Verification
REQ-037 Single source: NUM_CH=4, req on ch2, mac_tx_ack 3 cycles later -> ch_tx_ack=4'b0100 for 1 cycle, grant_ch=2, ch2 data appears on mac_tx_data unchanged, and IDLE is re-entered 12 cycles after mac_send_end.
REQ-038 Fairness: PRIO_CH0=0, ch1/ch2/ch3 held requesting -> grants in the order 1,2,3,1 across 4 frames.
REQ-039 Priority: PRIO_CH0=1, ch0 and ch3 requesting, with ch0 re-requesting each frame -> ch0 granted every time; ch3 is granted as soon as ch0 drops.
REQ-040 Timeout: TIMEOUT_CYCLES=16, mac_tx_ack never asserted -> timeout_err pulses 16 cycles after MREQ entry, no ch_tx_ack occurs, and last_grant is unchanged.
REQ-041 Coincidence and reset: mac_send_end on the watchdog's final cycle -> GAP entered with no timeout_err; rst_n pulsed low mid-SEND -> all outputs 0 at once, and the next grant goes to ch0.
